// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - dump FSM state encoding and word/byte width constants
package risc_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    FINISH
  } dump_state_t;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// rtl/data_ram_arbiter_if.sv - CPU load/store port toward the data RAM arbiter
interface data_ram_arbiter_if
  import risc_pkg::*;
#(
  parameter int AW = 5
);

  logic              req;
  logic              we;
  logic [AW-1:0]     addr;
  logic [WORD_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [WORD_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - holds one RAM word and streams it out LSB byte first
module word_byte_serializer
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              tready,
  output logic [BYTE_W-1:0] tdata,
  output logic              tvalid,
  output logic              empty
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [WORD_W-1:0] buffer;
  logic [IDX_W-1:0]  index;
  logic              take;

  assign take  = tvalid && tready;
  assign tdata = buffer[BYTE_W-1:0];
  // empty fires on the handshake that consumes the last byte of the word
  assign empty = take && (index == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer <= '0;
      index  <= '0;
      tvalid <= 1'b0;
    end else if (load) begin
      buffer <= word;
      index  <= '0;
      tvalid <= 1'b1;
    end else if (take) begin
      buffer <= buffer >> BYTE_W;
      index  <= index + IDX_W'(1);
      if (empty) begin
        tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - shares the data RAM between the CPU port and a byte-streaming dump engine
module data_ram_arbiter
  import risc_pkg::*;
#(
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 8
)
(
  input  logic              clk,
  input  logic              rst,
  data_ram_arbiter_if.slave cpu,
  input  logic              dump_start,
  input  logic [AW-1:0]     dump_base,
  input  logic [AW:0]       dump_len,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  dump_state_t      state;
  dump_state_t      state_next;
  logic [AW-1:0]    addr;
  logic [AW:0]      remain;
  logic [CNT_W-1:0] starve_cnt;
  logic             dump_req;
  logic             force_dump;
  logic             dump_gnt;
  logic             word_done;

  // CPU wins every cycle except when the dump has waited STARVE_LIMIT cycles
  assign dump_req   = (state == FETCH);
  assign force_dump = dump_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign cpu.gnt    = cpu.req && !force_dump;
  assign dump_gnt   = dump_req && (!cpu.req || force_dump);

  assign ram_we     = cpu.gnt && cpu.we;
  assign ram_addr   = cpu.gnt ? cpu.addr : addr;
  assign ram_wdata  = cpu.gnt ? cpu.wdata : '0;
  assign cpu.rdata  = ram_rdata;
  assign dump_busy  = (state != IDLE);

  word_byte_serializer u_serializer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == WAIT),
    .word   (ram_rdata),
    .tready (byte_ready),
    .tdata  (byte_out),
    .tvalid (byte_valid),
    .empty  (word_done)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (dump_start) state_next = (dump_len == '0) ? FINISH : FETCH;
      FETCH:   if (dump_gnt) state_next = WAIT;
      WAIT:    state_next = SEND;
      SEND:    if (word_done) state_next = (remain == (AW+1)'(1)) ? FINISH : FETCH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      remain     <= '0;
      starve_cnt <= '0;
      cpu.rvalid <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      state      <= state_next;
      cpu.rvalid <= cpu.gnt && !cpu.we;
      dump_done  <= (state == FINISH);
      if ((state == IDLE) && dump_start) begin
        addr   <= dump_base;
        remain <= dump_len;
      end else if (word_done) begin
        addr   <= addr + AW'(1);
        remain <= remain - (AW+1)'(1);
      end
      if (!dump_req || dump_gnt) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - directed and randomized bench against a queue-based arbiter/dump model
module tb_data_ram_arbiter;

  localparam int AW    = 5;
  localparam int LIMIT = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          dump_start;
  logic [AW-1:0] dump_base;
  logic [AW:0]   dump_len;
  logic          dump_busy;
  logic          dump_done;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  data_ram_arbiter_if #(.AW(AW)) cpu ();

  data_ram_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu),
    .dump_start (dump_start),
    .dump_base  (dump_base),
    .dump_len   (dump_len),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // single-port RAM with one-cycle read latency
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: expected RAM image, pending dump words and the byte lane as a queue
  logic [31:0]   ref_mem [DEPTH];
  bit            m_live, m_busy, m_fetch, m_load, m_finish, m_done, m_rvalid;
  logic [31:0]   m_rdata, m_word;
  int            m_left, m_denied;
  logic [AW-1:0] m_addr;
  logic [7:0]    bq [$];

  function automatic bit m_forced();
    return m_fetch && (m_denied == LIMIT);
  endfunction
  function automatic bit m_cpu_grant();
    return cpu.req && !m_forced();
  endfunction
  function automatic bit m_dump_grant();
    return m_fetch && (!cpu.req || m_forced());
  endfunction

  always @(posedge clk) begin : model_p
    bit gc, gd, take, was_fetch, old_busy;
    gc = m_cpu_grant();
    gd = m_dump_grant();
    was_fetch = m_fetch;
    old_busy = m_busy;
    take = (bq.size() != 0) && byte_ready;
    if (m_live) begin
      m_rvalid = gc && !cpu.we;
      m_rdata  = ref_mem[cpu.addr];
      if (gc && cpu.we) ref_mem[cpu.addr] = cpu.wdata;
    end
    if (rst) begin
      m_live = 1; m_busy = 0; m_fetch = 0; m_load = 0; m_finish = 0; m_done = 0;
      m_rvalid = 0; m_left = 0; m_denied = 0; m_addr = '0;
      bq.delete();
    end else if (m_live) begin
      m_done = m_finish;
      if (m_finish) begin
        m_finish = 0;
        m_busy = 0;
      end
      if (m_load) begin
        for (int b = 0; b < 4; b++) bq.push_back(m_word[8*b +: 8]);
        m_load = 0;
      end else if (take) begin
        void'(bq.pop_front());
        if (bq.size() == 0) begin
          m_left--;
          m_addr = m_addr + AW'(1);
          if (m_left == 0) m_finish = 1;
          else m_fetch = 1;
        end
      end
      if (gd) begin
        m_word = ref_mem[m_addr];
        m_fetch = 0;
        m_load = 1;
        m_denied = 0;
      end else if (was_fetch) begin
        m_denied = (m_denied < LIMIT) ? m_denied + 1 : LIMIT;
      end else begin
        m_denied = 0;
      end
      if (!old_busy && dump_start) begin
        m_busy = 1;
        m_addr = dump_base;
        m_left = int'(dump_len);
        if (dump_len == '0) m_finish = 1;
        else m_fetch = 1;
      end
    end
  end

  // per-cycle comparison plus stream/event capture for the directed pins
  logic [7:0] got [$];
  bit         done_seen, bv_seen, last_gnt;
  int         done_cyc, stall_cnt;

  always @(negedge clk) begin
    if (m_live) begin
      check("cpu_gnt", 32'(cpu.gnt), 32'(m_cpu_grant()));
      check("ram_we", 32'(ram_we), 32'(m_cpu_grant() && cpu.we));
      if (m_cpu_grant()) begin
        check("ram_addr_cpu", 32'(ram_addr), 32'(cpu.addr));
        if (cpu.we) check("ram_wdata", ram_wdata, cpu.wdata);
      end else if (m_dump_grant()) begin
        check("ram_addr_dump", 32'(ram_addr), 32'(m_addr));
      end
      check("cpu_rvalid", 32'(cpu.rvalid), 32'(m_rvalid));
      if (m_rvalid) check("cpu_rdata", cpu.rdata, m_rdata);
      check("dump_busy", 32'(dump_busy), 32'(m_busy));
      check("dump_done", 32'(dump_done), 32'(m_done));
      check("byte_valid", 32'(byte_valid), 32'(bq.size() != 0));
      if (bq.size() != 0) check("byte_out", 32'(byte_out), 32'(bq[0]));
    end
    if (byte_valid && byte_ready) got.push_back(byte_out);
    if (byte_valid) bv_seen = 1;
    if (dump_done) begin
      done_seen = 1;
      done_cyc = cyc;
    end
    if (cpu.req && !cpu.gnt) stall_cnt++;
    last_gnt = cpu.gnt;
  end

  logic [31:0] written [DEPTH];
  logic [7:0]  exp_q [$];
  int          start_cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu.req = 0; cpu.we = 0; cpu.addr = '0; cpu.wdata = '0;
    dump_start = 0; dump_base = '0; dump_len = '0; byte_ready = 1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] d);
    cpu.req = 1; cpu.we = 1; cpu.addr = a; cpu.wdata = d;
    written[a] = d;
    step();
    cpu.req = 0; cpu.we = 0;
  endtask

  task automatic start_dump(input logic [AW-1:0] b, input logic [AW:0] l);
    got.delete(); done_seen = 0; bv_seen = 0; start_cyc = cyc;
    dump_start = 1; dump_base = b; dump_len = l;
    step();
    dump_start = 0;
  endtask

  task automatic wait_done(input int mode, input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      case (mode)
        0:       byte_ready = 1;
        1:       byte_ready = (n % 3 == 0);
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      n++;
    end
    byte_ready = 1;
    check("done_in_budget", 32'(done_seen), 32'd1);
  endtask

  task automatic check_stream(input string name);
    check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check(name, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    @(negedge clk);
    check("rst_busy", 32'(dump_busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_rvalid", 32'(cpu.rvalid), 32'd0);

    for (int i = 0; i < DEPTH; i++) cpu_write(AW'(i), $urandom);
    cpu_write(5'd3, 32'hA1B2C3D4);
    cpu_write(5'd30, 32'h11111111);
    cpu_write(5'd31, 32'h22222222);
    cpu_write(5'd0, 32'h33333333);

    // single word, consumer always ready
    start_dump(5'd3, 6'd1);
    wait_done(0, 40);
    exp_q = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    check_stream("t1_bytes");
    check("t1_done_latency", 32'(done_cyc - start_cyc), 32'd8);
    step();
    check("t1_busy_after", 32'(dump_busy), 32'd0);

    // same word under backpressure
    start_dump(5'd3, 6'd1);
    wait_done(1, 80);
    check_stream("bp_bytes");

    // address wrap 30, 31, 0
    start_dump(5'd30, 6'd3);
    wait_done(0, 80);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h11);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h22);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h33);
    check_stream("wrap_bytes");

    // CPU holds request through a two-word dump
    stall_cnt = 0; k = 0;
    cpu.req = 1; cpu.we = 1; cpu.addr = 5'd16; cpu.wdata = $urandom;
    start_dump(5'd5, 6'd2);
    for (int n = 0; n < 200 && !done_seen; n++) begin
      if (last_gnt) begin
        k++;
        cpu.addr = AW'(16 + k % 8);
        cpu.wdata = $urandom;
      end
      step();
    end
    cpu.req = 0; cpu.we = 0;
    check("starve_done", 32'(done_seen), 32'd1);
    check("starve_stalls", 32'(stall_cnt), 32'd2);
    exp_q.delete();
    for (int w = 5; w < 7; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(written[w][8*b +: 8]);
    check_stream("starve_bytes");

    // write then immediate read-back
    cpu_write(5'd7, 32'hDEADBEEF);
    cpu.req = 1; cpu.we = 0; cpu.addr = 5'd7;
    step();
    cpu.req = 0;
    @(negedge clk);
    check("rd_rvalid", 32'(cpu.rvalid), 32'd1);
    check("rd_rdata", cpu.rdata, 32'hDEADBEEF);

    // zero-length dump
    step();
    start_dump(5'd9, 6'd0);
    wait_done(0, 20);
    check("len0_latency", 32'(done_cyc - start_cyc), 32'd2);
    check("len0_no_bytes", 32'(bv_seen), 32'd0);

    // reset while a byte is held
    step();
    start_dump(5'd10, 6'd2);
    byte_ready = 0;
    for (int n = 0; n < 40 && !byte_valid; n++) step();
    check("rs_in_send", 32'(byte_valid), 32'd1);
    done_seen = 0;
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("rs_byte_valid", 32'(byte_valid), 32'd0);
    check("rs_byte_out", 32'(byte_out), 32'd0);
    check("rs_busy", 32'(dump_busy), 32'd0);
    for (int n = 0; n < 10; n++) step();
    check("rs_no_done", 32'(done_seen), 32'd0);
    byte_ready = 1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(cpu.req && !last_gnt)) begin
        cpu.req   = ($urandom_range(0, 2) == 0);
        cpu.we    = 1'($urandom_range(0, 1));
        cpu.addr  = AW'($urandom_range(0, DEPTH - 1));
        cpu.wdata = $urandom;
      end
      dump_start = ($urandom_range(0, 15) == 0);
      dump_base  = AW'($urandom_range(0, DEPTH - 1));
      dump_len   = ($urandom_range(0, 20) == 0) ? 6'd32 : 6'($urandom_range(0, 4));
      byte_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    for (int n = 0; n < 10; n++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
